// File: rtl/ex_issue_ctrl.sv
// Issue controller between decode and execute: two-entry skid queue
// (main + skid register) with in-order issue, flush, and stall/issue counters.
module ex_issue_ctrl #(
  parameter int unsigned INSTR_W = 96,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               alu_valid,
  input  logic               alu_ready,
  output logic [INSTR_W-1:0] alu_instr,
  input  logic               flush,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   issue_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] main_q, main_d;
  logic [INSTR_W-1:0] skid_q, skid_d;
  logic               in_xfer;
  logic               out_xfer;
  logic               stall_c;

  // Handshakes decode only from registered state and flush, never from in_valid.
  assign in_ready  = (state_q != FULL)  && !flush;
  assign alu_valid = (state_q != EMPTY) && !flush;
  assign alu_instr = main_q;

  assign in_xfer  = in_valid  && in_ready;
  assign out_xfer = alu_valid && alu_ready;
  assign stall_c  = alu_valid && !alu_ready;

  // State and queue registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and queue data selection; flush overrides any transfer.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = in_instr;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_instr;
          end else if (in_xfer) begin
            skid_d  = in_instr;
            state_d = FULL;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Performance counters: stall saturates, issue wraps; flush leaves both alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if (stall_c && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (out_xfer) begin
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
    end
  end

endmodule
